// File: rtl/fu_mem_arbiter_if.sv
// Bundle between the load/store buffers, the arbiter and FU_mem.
// The slave view belongs to the arbiter; the master view drives requests, models FU_mem and consumes responses.
interface fu_mem_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_mem_w;
  logic [2:0]       req0_bhw;
  logic [31:0]      req0_rs1;
  logic [31:0]      req0_rs2;
  logic [31:0]      req0_imm;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_mem_w;
  logic [2:0]       req1_bhw;
  logic [31:0]      req1_rs1;
  logic [31:0]      req1_rs2;
  logic [31:0]      req1_imm;
  logic [TAG_W-1:0] req1_tag;

  logic             fu_EN;
  logic             fu_mem_w;
  logic [2:0]       fu_bhw;
  logic [31:0]      fu_rs1;
  logic [31:0]      fu_rs2;
  logic [31:0]      fu_imm;
  logic             fu_finish;
  logic [31:0]      fu_mem_data;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_is_store;
  logic             resp_err;
  logic             busy;
  logic             err_sticky;

  modport slave (
    input  req0_valid, req0_mem_w, req0_bhw, req0_rs1, req0_rs2, req0_imm, req0_tag,
    output req0_ready,
    input  req1_valid, req1_mem_w, req1_bhw, req1_rs1, req1_rs2, req1_imm, req1_tag,
    output req1_ready,
    output fu_EN, fu_mem_w, fu_bhw, fu_rs1, fu_rs2, fu_imm,
    input  fu_finish, fu_mem_data,
    output resp_valid, resp_id, resp_tag, resp_data, resp_is_store, resp_err,
    input  resp_ready,
    output busy, err_sticky
  );

  modport master (
    output req0_valid, req0_mem_w, req0_bhw, req0_rs1, req0_rs2, req0_imm, req0_tag,
    input  req0_ready,
    output req1_valid, req1_mem_w, req1_bhw, req1_rs1, req1_rs2, req1_imm, req1_tag,
    input  req1_ready,
    input  fu_EN, fu_mem_w, fu_bhw, fu_rs1, fu_rs2, fu_imm,
    output fu_finish, fu_mem_data,
    input  resp_valid, resp_id, resp_tag, resp_data, resp_is_store, resp_err,
    output resp_ready,
    input  busy, err_sticky
  );
endinterface

// File: rtl/fu_mem_arbiter.sv
// Round-robin arbiter sharing FU_mem between load and store buffers; accept->resp_valid is 3 cycles when FU finishes at once.
// One op in flight: requesters see ready only in IDLE, and the response is held until resp_ready.
module fu_mem_arbiter #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  fu_mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        mem_w;
    logic [2:0]  bhw;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } op_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             winner;
  logic             accept;
  logic             timeout;
  logic [CNT_W-1:0] wd_cnt;
  op_t              op0;
  op_t              op1;
  op_t              op_q;
  logic [TAG_W-1:0] tag_q;
  logic             id_q;
  logic             rdy0;
  logic             rdy1;
  logic             fu_en;

  assign op0 = {bus.req0_mem_w, bus.req0_bhw, bus.req0_rs1, bus.req0_rs2, bus.req0_imm};
  assign op1 = {bus.req1_mem_w, bus.req1_bhw, bus.req1_rs1, bus.req1_rs2, bus.req1_imm};

  // Contention goes to rr_ptr; otherwise the only valid requester wins.
  assign winner  = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
  assign timeout = (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    accept    = 1'b0;
    fu_en     = 1'b0;
    case (state)
      IDLE: begin
        rdy0   = bus.req0_valid && !winner;
        rdy1   = bus.req1_valid &&  winner;
        accept = bus.req0_valid || bus.req1_valid;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        fu_en     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.fu_finish || timeout) state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.fu_EN      = fu_en;
  assign bus.busy       = (state != IDLE);
  assign bus.fu_mem_w   = op_q.mem_w;
  assign bus.fu_bhw     = op_q.bhw;
  assign bus.fu_rs1     = op_q.rs1;
  assign bus.fu_rs2     = op_q.rs2;
  assign bus.fu_imm     = op_q.imm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr            <= 1'b0;
      op_q              <= '0;
      tag_q             <= '0;
      id_q              <= 1'b0;
      wd_cnt            <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_id       <= 1'b0;
      bus.resp_tag      <= '0;
      bus.resp_data     <= '0;
      bus.resp_is_store <= 1'b0;
      bus.resp_err      <= 1'b0;
      bus.err_sticky    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= ~winner;
            id_q   <= winner;
            op_q   <= winner ? op1 : op0;
            tag_q  <= winner ? bus.req1_tag : bus.req0_tag;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          // Finish wins over a timeout landing in the same cycle.
          if (bus.fu_finish || timeout) begin
            bus.resp_valid    <= 1'b1;
            bus.resp_id       <= id_q;
            bus.resp_tag      <= tag_q;
            bus.resp_is_store <= op_q.mem_w;
            bus.resp_err      <= !bus.fu_finish;
            bus.resp_data     <= (bus.fu_finish && !op_q.mem_w) ? bus.fu_mem_data : 32'h0;
            if (!bus.fu_finish) bus.err_sticky <= 1'b1;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) bus.resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fu_mem_arbiter.sv
// Directed sequence with randomized operands, checked against a transaction-level model of the arbiter.
module tb_fu_mem_arbiter;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fu_mem_arbiter_if #(.TAG_W(TAG_W)) bus ();

  fu_mem_arbiter #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: next round-robin favourite and expected sticky error flag.
  bit rr_exp     = 1'b0;
  bit sticky_exp = 1'b0;

  logic             f_mem_w [2];
  logic [2:0]       f_bhw   [2];
  logic [31:0]      f_rs1   [2];
  logic [31:0]      f_rs2   [2];
  logic [31:0]      f_imm   [2];
  logic [TAG_W-1:0] f_tag   [2];
  logic [31:0]      fu_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 2; i++) begin
      f_mem_w[i] = 1'($urandom_range(0, 1));
      f_bhw[i]   = 3'($urandom_range(0, 7));
      f_rs1[i]   = $urandom;
      f_rs2[i]   = $urandom;
      f_imm[i]   = $urandom;
      f_tag[i]   = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    end
    fu_rdata = $urandom;
  endtask

  task automatic drive_fields();
    bus.req0_mem_w = f_mem_w[0]; bus.req0_bhw = f_bhw[0]; bus.req0_rs1 = f_rs1[0];
    bus.req0_rs2   = f_rs2[0];   bus.req0_imm = f_imm[0]; bus.req0_tag = f_tag[0];
    bus.req1_mem_w = f_mem_w[1]; bus.req1_bhw = f_bhw[1]; bus.req1_rs1 = f_rs1[1];
    bus.req1_rs2   = f_rs2[1];   bus.req1_imm = f_imm[1]; bus.req1_tag = f_tag[1];
  endtask

  task automatic chk_resp(input string ph, input bit id, input logic [TAG_W-1:0] tag,
                          input bit st, input logic [31:0] data, input bit err);
    chk({ph, "_valid"}, bus.resp_valid, 1'b1);
    chk({ph, "_id"}, bus.resp_id, id);
    chk({ph, "_tag"}, bus.resp_tag, tag);
    chk({ph, "_data"}, bus.resp_data, data);
    chk({ph, "_is_store"}, bus.resp_is_store, st);
    chk({ph, "_err"}, bus.resp_err, err);
  endtask

  // One transaction from the current IDLE cycle: d = FU finish delay after the first WAIT
  // cycle (negative = never), h = cycles resp_ready is held low, spur = stray finish in RESP.
  task automatic run_op(input bit v0, input bit v1, input bit keep, input int d, input int h, input bit spur);
    bit          w;
    bit          st;
    logic [31:0] ed;
    bit          ee;
    drive_fields();
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.resp_ready = (h == 0);
    #1;
    w = (v0 && v1) ? rr_exp : v1;
    chk("accept_rdy0", bus.req0_ready, v0 && !w);
    chk("accept_rdy1", bus.req1_ready, v1 && w);
    chk("idle_busy", bus.busy, 1'b0);
    rr_exp = !w;
    st = f_mem_w[w];
    tick();
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    #1;
    chk("issue_en", bus.fu_EN, 1'b1);
    chk("issue_rdy0", bus.req0_ready, 1'b0);
    chk("issue_rdy1", bus.req1_ready, 1'b0);
    chk("issue_busy", bus.busy, 1'b1);
    chk("issue_rs1", bus.fu_rs1, f_rs1[w]);
    chk("issue_rs2", bus.fu_rs2, f_rs2[w]);
    chk("issue_imm", bus.fu_imm, f_imm[w]);
    chk("issue_bhw", bus.fu_bhw, f_bhw[w]);
    chk("issue_mem_w", bus.fu_mem_w, f_mem_w[w]);
    tick();
    chk("wait_en", bus.fu_EN, 1'b0);
    if (d < 0) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        chk("wd_no_resp", bus.resp_valid, 1'b0);
        tick();
      end
      chk("wd_rs1_hold", bus.fu_rs1, f_rs1[w]);
      ed = 32'h0;
      ee = 1'b1;
      sticky_exp = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) begin
        chk("wait_no_resp", bus.resp_valid, 1'b0);
        chk("wait_imm_hold", bus.fu_imm, f_imm[w]);
        tick();
      end
      bus.fu_finish   = 1'b1;
      bus.fu_mem_data = fu_rdata;
      tick();
      bus.fu_finish = 1'b0;
      ed = st ? 32'h0 : fu_rdata;
      ee = 1'b0;
    end
    chk_resp("resp", w, f_tag[w], st, ed, ee);
    chk("resp_sticky", bus.err_sticky, sticky_exp);
    for (int i = 0; i < h; i++) begin
      if (spur && i == 0) begin
        bus.fu_finish   = 1'b1;
        bus.fu_mem_data = ~fu_rdata;
      end
      tick();
      bus.fu_finish = 1'b0;
      chk_resp("hold", w, f_tag[w], st, ed, ee);
      chk("hold_rdy0", bus.req0_ready, 1'b0);
      chk("hold_rdy1", bus.req1_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("done_valid", bus.resp_valid, 1'b0);
    chk("done_busy", bus.busy, 1'b0);
    chk("done_sticky", bus.err_sticky, sticky_exp);
  endtask

  initial begin
    int pat;
    rand_fields();
    drive_fields();
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.fu_finish   = 1'b0;
    bus.fu_mem_data = 32'h0;
    bus.resp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_tag", bus.resp_tag, 0);
    chk("rst_fu_en", bus.fu_EN, 1'b0);
    chk("rst_fu_rs1", bus.fu_rs1, 0);
    chk("rst_err_sticky", bus.err_sticky, 1'b0);
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    rst = 1'b1;
    tick();

    // Single req0 load with known operands.
    rand_fields();
    f_mem_w[0] = 1'b0; f_rs1[0] = 32'h100; f_imm[0] = 32'h4; f_bhw[0] = 3'b010; f_tag[0] = 4'd5;
    fu_rdata = 32'hDEAD_BEEF;
    run_op(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    // req1 store, response stalled 5 cycles, stray finish in RESP, requester kept valid.
    rand_fields();
    f_mem_w[1] = 1'b1; f_rs2[1] = 32'h55;
    run_op(1'b0, 1'b1, 1'b1, 0, 5, 1'b1);

    // Both requesters valid back to back: grants must alternate.
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      run_op(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    end

    // FU never finishes: watchdog abort.
    rand_fields();
    run_op(1'b1, 1'b0, 1'b0, -1, 0, 1'b0);

    // Randomized traffic; the sticky error must persist.
    for (int i = 0; i < 12; i++) begin
      rand_fields();
      pat = int'($urandom_range(1, 3));
      run_op(pat[0], pat[1], 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Stray finish while idle.
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.fu_finish  = 1'b1;
    tick();
    bus.fu_finish = 1'b0;
    chk("spur_idle_valid", bus.resp_valid, 1'b0);
    chk("spur_idle_busy", bus.busy, 1'b0);
    tick();
    chk("spur_idle_valid2", bus.resp_valid, 1'b0);

    // Asynchronous reset in WAIT after a req0 accept.
    rand_fields();
    drive_fields();
    bus.req0_valid = 1'b1;
    #1;
    chk("pre_rst_rdy0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_fu_en", bus.fu_EN, 1'b0);
    chk("arst_fu_rs1", bus.fu_rs1, 0);
    chk("arst_fu_imm", bus.fu_imm, 0);
    chk("arst_resp_valid", bus.resp_valid, 1'b0);
    chk("arst_resp_data", bus.resp_data, 0);
    chk("arst_err_sticky", bus.err_sticky, 1'b0);
    tick();
    rst = 1'b1;
    rr_exp = 1'b0;
    sticky_exp = 1'b0;
    rand_fields();
    run_op(1'b1, 1'b1, 1'b0, 1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
